dram_store_buf: RTL
===================

Name: dram_store_buf

Overview:
- Store buffer between the hxd32 core's data-memory port and the DRAM write port.
- Core stores (address, data, byte enables) are queued in a small FIFO and drained to DRAM through a valid/ready handshake.
- Core loads read DRAM combinationally.
- Bytes still pending in the buffer are forwarded into load data so loads always see program order.
- cpu_stall_o tells the core to hold when the buffer cannot accept a store.

Parameters:
- XLEN, 32, data/address width.
- DEPTH, 4, number of buffer entries; power of two, at least 2.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- cpu_wr_addr_i  in  XLEN  store address; bits [1:0] ignored, lanes already aligned
- cpu_wr_data_i  in  XLEN  lane-aligned store data
- cpu_wr_byte_en_i  in  4  store byte enables; nonzero means a store request this cycle
- cpu_rd_en_i  in  1  load request this cycle
- cpu_rd_addr_i  in  XLEN  load address
- cpu_rd_data_o  out  XLEN  load word; combinational, after forwarding merge
- cpu_stall_o  out  1  core must hold its current instruction
- mem_wr_valid_o  out  1  head entry valid
- mem_wr_ready_i  in  1  DRAM accepts the head entry
- mem_wr_addr_o  out  XLEN  head address; {addr[XLEN-1:2], 2'b00}
- mem_wr_data_o  out  XLEN  head data
- mem_wr_byte_en_o  out  4  head byte enables
- mem_rd_addr_o  out  XLEN  equals cpu_rd_addr_i
- mem_rd_data_i  in  XLEN  combinational DRAM read data

Behaviour:
- Reset is synchronous, rst_i high at a clock edge. It clears count, head and tail pointers, and all entry valid bits. Pending stores are discarded.
  - Reset values: mem_wr_valid_o=0, mem_wr_byte_en_o=0, cpu_stall_o=0.
  - Entry data/address contents are don't-care.
- Entry fields: word address addr[XLEN-1:2], data, byte_en. Head = oldest entry.
- Signals:
  - pop = mem_wr_valid_o & mem_wr_ready_i
  - push = (cpu_wr_byte_en_i != 0) & ~cpu_stall_o
- Pointers and count:
  - Tail advances on push, head on pop; both wrap modulo DEPTH.
  - count (0..DEPTH) changes by push − pop.
  - Simultaneous push and pop leaves count unchanged, including at full and at empty.
- mem_wr_valid_o = (count != 0). Head fields are driven from registers with no combinational path from cpu inputs.
- Push while empty: the entry is visible on mem_wr_* in the next cycle (1-cycle latency). A store never bypasses the buffer.
- Stall conditions:
  - cpu_stall_o = (store request & count==DEPTH & ~pop), OR the load condition under the optional feature.
  - A stall on a store does not enqueue it; the core re-presents the store next cycle.
- Load without a match: cpu_rd_data_o = mem_rd_data_i.
- Forwarding:
  - For each byte lane, scan valid entries from oldest to youngest whose word address equals cpu_rd_addr_i[XLEN-1:2] and whose byte_en bit is set.
  - The youngest matching entry supplies the byte; lanes with no match take mem_rd_data_i.
  - The head being popped this cycle still participates, because DRAM commits its write at the clock edge.
- A store pushed in the same cycle as a load is not forwarded to that load. Load and store in the same cycle is illegal, since the core issues one memory op per instruction; the bench asserts on it.
- cpu_rd_data_o is don't-care when cpu_rd_en_i=0; the forwarding logic only needs to qualify the stall.
- DRAM backpressure: mem_wr_* must stay stable while valid & ~ready, and the head may not change until pop.

Optional Feature:
- DRAM_SBUF_FWD_EN
  - Defined: byte forwarding as described above; loads never stall.
  - Undefined: no merge logic. cpu_rd_data_o = mem_rd_data_i. cpu_stall_o additionally asserts while cpu_rd_en_i=1 and any valid entry's word address matches cpu_rd_addr_i. The stall clears once the matching entries have drained.

Decomposition:
- Package hxd32_sbuf_pkg:
  - sbuf_entry_t packed struct {waddr, data, byte_en}, parameterised via XLEN-derived widths
  - constant BYTE_LANES=4
  - function word_addr()
- Natural sub-module sbuf_fwd: combinational per-lane youngest-match merge, given entry array, valid mask, head pointer and load address. Instantiated only under DRAM_SBUF_FWD_EN.

Test Plan:
- Reset then single store: store addr 0x100, data 0xDEADBEEF, be 4'hF, with mem_wr_ready_i=1. Required: mem_wr_valid_o=1 next cycle with addr 0x100, data 0xDEADBEEF; count returns to 0 after that cycle.
- Fill and stall: hold mem_wr_ready_i=0 and issue 5 stores. Required: first 4 accepted; cpu_stall_o=1 on the 5th. Raise ready: the 5th is accepted in the pop cycle, count stays 4, drain order matches issue order.
- Byte forward merge: mem_wr_ready_i=0, mem_rd_data_i=0x11223344. Store addr 0x200, data 0x000000AA, be 4'b0001; then store addr 0x202, data 0x00BB0000, be 4'b0100; then load 0x200. Required: cpu_rd_data_o=0x11BB33AA.
- Youngest wins: two stores to 0x300 with be 4'hF, data 0x1 then 0x2; load 0x300. Required: 0x00000002. Without the macro: stall until both have drained.
- Reset mid-operation: 3 pending entries, rst_i=1 for one cycle. Required: mem_wr_valid_o=0 next cycle, no further DRAM writes, and a load to a previously buffered address returns mem_rd_data_i.
- Backpressure stability: ready toggles 0,0,1 with 2 entries pending. Required: mem_wr_* unchanged during the low cycles, then the second entry is presented.

Source files
------------

// File: rtl/dram_store_buf_pkg.sv
// hxd32 store-buffer shared types.
//   sbuf_entry_t : one buffered store (word address, lane-aligned data, byte enables)
//   BYTE_LANES   : byte lanes per data word
//   word_addr()  : strips the byte offset from a byte address
// The entry layout is sized by SBUF_XLEN; dram_store_buf's XLEN must match it.
package hxd32_sbuf_pkg;

  localparam int unsigned SBUF_XLEN  = 32;
  localparam int unsigned BYTE_LANES = 4;
  localparam int unsigned WADDR_W    = SBUF_XLEN - 2;

  typedef struct packed {
    logic [WADDR_W-1:0]    waddr;
    logic [SBUF_XLEN-1:0]  data;
    logic [BYTE_LANES-1:0] byte_en;
  } sbuf_entry_t;

  function automatic logic [WADDR_W-1:0] word_addr(input logic [SBUF_XLEN-1:0] addr);
    return addr[SBUF_XLEN-1:2];
  endfunction

endpackage

// File: rtl/dram_store_buf_fwd.sv
// sbuf_fwd: combinational load-data merge for the store buffer.
//   entries   : buffer storage, indexed by physical slot
//   valid     : per-slot valid mask
//   head      : slot of the oldest entry
//   rd_addr   : load byte address
//   base_data : DRAM read data used for lanes with no pending store
//   rd_data   : merged load word
// Slots are walked oldest to youngest so a later match overwrites an earlier
// one; the last writer of each lane therefore wins.
module sbuf_fwd
  import hxd32_sbuf_pkg::*;
#(
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned PTR_W = $clog2(DEPTH)
) (
  input  sbuf_entry_t           entries [DEPTH],
  input  logic [DEPTH-1:0]      valid,
  input  logic [PTR_W-1:0]      head,
  input  logic [SBUF_XLEN-1:0]  rd_addr,
  input  logic [SBUF_XLEN-1:0]  base_data,
  output logic [SBUF_XLEN-1:0]  rd_data
);

  logic [PTR_W-1:0] idx;

  always_comb begin
    rd_data = base_data;
    idx     = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      idx = head + PTR_W'(k);
      if (valid[idx] && (entries[idx].waddr == word_addr(rd_addr))) begin
        for (int unsigned lane = 0; lane < BYTE_LANES; lane++) begin
          if (entries[idx].byte_en[lane]) begin
            rd_data[8*lane +: 8] = entries[idx].data[8*lane +: 8];
          end
        end
      end
    end
  end

endmodule

// File: rtl/dram_store_buf.sv
// dram_store_buf: store buffer between the hxd32 data-memory port and DRAM.
//   clk_i, rst_i            : clock, synchronous active-high reset
//   cpu_wr_*                : core store request (byte_en != 0 means a store)
//   cpu_rd_en_i/addr_i      : core load request
//   cpu_rd_data_o           : load word (combinational)
//   cpu_stall_o             : core must hold its current instruction
//   mem_wr_*                : valid/ready write port driven from the oldest entry
//   mem_rd_addr_o/data_i    : combinational DRAM read port
// Build option DRAM_SBUF_FWD_EN: when defined, pending store bytes are merged
// into load data; when undefined, a load hitting a pending word stalls until
// the matching entries have drained.
module dram_store_buf
  import hxd32_sbuf_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [XLEN-1:0] cpu_wr_addr_i,
  input  logic [XLEN-1:0] cpu_wr_data_i,
  input  logic [3:0]      cpu_wr_byte_en_i,
  input  logic            cpu_rd_en_i,
  input  logic [XLEN-1:0] cpu_rd_addr_i,
  output logic [XLEN-1:0] cpu_rd_data_o,
  output logic            cpu_stall_o,
  output logic            mem_wr_valid_o,
  input  logic            mem_wr_ready_i,
  output logic [XLEN-1:0] mem_wr_addr_o,
  output logic [XLEN-1:0] mem_wr_data_o,
  output logic [3:0]      mem_wr_byte_en_o,
  output logic [XLEN-1:0] mem_rd_addr_o,
  input  logic [XLEN-1:0] mem_rd_data_i
);

  localparam int unsigned PTR_W      = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);

  sbuf_entry_t      entries [DEPTH];
  logic [DEPTH-1:0] valid;
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [PTR_W:0]   count;

  logic store_req;
  logic push;
  logic pop;
  logic load_stall;

  assign store_req   = |cpu_wr_byte_en_i;
  assign pop         = mem_wr_valid_o & mem_wr_ready_i;
  // A full buffer still accepts a store in the cycle its head drains.
  assign cpu_stall_o = (store_req & (count == FULL_COUNT) & ~pop) | load_stall;
  assign push        = store_req & ~cpu_stall_o;

  assign mem_wr_valid_o   = (count != '0);
  assign mem_wr_addr_o    = {entries[head].waddr, 2'b00};
  assign mem_wr_data_o    = entries[head].data;
  assign mem_wr_byte_en_o = mem_wr_valid_o ? entries[head].byte_en : '0;
  assign mem_rd_addr_o    = cpu_rd_addr_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      valid <= '0;
    end else begin
      // At full, head == tail on a push+pop; the push's set must win.
      if (pop) begin
        valid[head] <= 1'b0;
        head        <= head + 1'b1;
      end
      if (push) begin
        valid[tail] <= 1'b1;
        tail        <= tail + 1'b1;
      end
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      entries[tail] <= '{waddr:   word_addr(cpu_wr_addr_i),
                         data:    cpu_wr_data_i,
                         byte_en: cpu_wr_byte_en_i};
    end
  end

`ifdef DRAM_SBUF_FWD_EN
  logic unused_rd_en;
  assign unused_rd_en = cpu_rd_en_i;
  assign load_stall   = 1'b0;

  sbuf_fwd #(
    .DEPTH (DEPTH)
  ) u_fwd (
    .entries   (entries),
    .valid     (valid),
    .head      (head),
    .rd_addr   (cpu_rd_addr_i),
    .base_data (mem_rd_data_i),
    .rd_data   (cpu_rd_data_o)
  );
`else
  logic rd_hit;

  always_comb begin
    rd_hit = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (valid[i] && (entries[i].waddr == word_addr(cpu_rd_addr_i))) begin
        rd_hit = 1'b1;
      end
    end
  end

  assign load_stall    = cpu_rd_en_i & rd_hit;
  assign cpu_rd_data_o = mem_rd_data_i;
`endif

endmodule
